// File: rtl/encoder_layer_0_attention_self_key_weight_sink.sv
// Key-weight sink: collects PARALLELISM_DIM_0-wide beats into rows of
// TENSOR_SIZE_DIM_0 elements and commits MEM_DEPTH rows into an internal RAM.
// The RAM has a two-stage registered readback port.
// Optional feature: define KEY_WEIGHT_SINK_CHECKSUM_EN to add a 32-bit
// running sum of every accepted element on output port checksum.
module encoder_layer_0_attention_self_key_weight_sink #(
    parameter int KEY_WEIGHT_PRECISION_0       = 16,
    parameter int KEY_WEIGHT_TENSOR_SIZE_DIM_0 = 32,
    parameter int KEY_WEIGHT_PARALLELISM_DIM_0 = 4,
    parameter int MEM_DEPTH                    = 576,
    localparam int BEATS  = KEY_WEIGHT_TENSOR_SIZE_DIM_0 / KEY_WEIGHT_PARALLELISM_DIM_0,
    localparam int AWIDTH = $clog2(MEM_DEPTH) + 1,
    localparam int ROW_W  = KEY_WEIGHT_PRECISION_0 * KEY_WEIGHT_TENSOR_SIZE_DIM_0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [KEY_WEIGHT_PRECISION_0-1:0] data_in [KEY_WEIGHT_PARALLELISM_DIM_0],
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    input  logic                              clear,
    output logic                              load_done,
    output logic [AWIDTH-1:0]                 row_count,
    input  logic [AWIDTH-1:0]                 rd_addr,
    input  logic                              rd_ce,
    output logic [ROW_W-1:0]                  rd_data
`ifdef KEY_WEIGHT_SINK_CHECKSUM_EN
    ,
    output logic [31:0]                       checksum
`endif
);

    localparam int P      = KEY_WEIGHT_PRECISION_0;
    localparam int PAR    = KEY_WEIGHT_PARALLELISM_DIM_0;
    localparam int BEAT_W = P * PAR;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMMIT  = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   beat_cnt;
    logic               started;
    logic               accept;
    logic               last_beat;
    logic               commit_en;
    logic [BEAT_W-1:0]  beat_packed;
    logic [BEAT_W-1:0]  row_buf [BEATS];
    logic [ROW_W-1:0]   row_flat;
    logic [ROW_W-1:0]   ram [MEM_DEPTH];
    logic [ROW_W-1:0]   rd_q1;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               rd_in_range;

    // Handshake and control qualifiers; clear always wins over a beat.
    assign data_in_ready = started && (state_q == COLLECT) && !clear;
    assign accept        = data_in_valid && data_in_ready;
    assign last_beat     = (beat_cnt == CNT_W'(BEATS - 1));
    assign commit_en     = (state_q == COMMIT) && !clear;
    assign load_done     = (state_q == DONE);
    assign rd_in_range   = (rd_addr < AWIDTH'(MEM_DEPTH));
    assign rd_idx        = rd_addr[IDX_W-1:0];
    assign wr_idx        = row_count[IDX_W-1:0];

    // Flatten the incoming beat and the collected row into bit vectors.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        beat_packed = '0;
        row_flat    = '0;
        for (int j = 0; j < PAR; j++) begin
            beat_packed[j*P +: P] = data_in[j];
        end
        for (int b = 0; b < BEATS; b++) begin
            row_flat[b*BEAT_W +: BEAT_W] = row_buf[b];
        end
    end

    // Next-state logic: collect beats, commit one row, stop after the last row.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (accept && last_beat) state_d = COMMIT;
            COMMIT:  state_d = (row_count == AWIDTH'(MEM_DEPTH - 1)) ? DONE : COLLECT;
            DONE:    state_d = DONE;
            default: state_d = COLLECT;
        endcase
        if (clear) begin
            state_d = COLLECT;
        end
    end

    // State, beat counter and row counter; started holds ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= COLLECT;
            beat_cnt  <= '0;
            row_count <= '0;
            started   <= 1'b0;
        end else begin
            started <= 1'b1;
            state_q <= state_d;
            if (clear) begin
                beat_cnt  <= '0;
                row_count <= '0;
            end else begin
                if (accept) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                end
                if (state_q == COMMIT) begin
                    row_count <= row_count + 1'b1;
                end
            end
        end
    end

    // Row assembly buffer; a partial row is abandoned simply by zeroing beat_cnt.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf[beat_cnt] <= beat_packed;
        end
    end

    // Row storage; committed in one cycle from the assembly buffer.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset: contents must survive reset and clear, and a reset would stop it mapping to memory.
        if (commit_en) begin
            ram[wr_idx] <= row_flat;
        end
    end

    // Two-stage readback; reads see pre-write data and out-of-range addresses read zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q1   <= '0;
            rd_data <= '0;
        end else if (rd_ce) begin
            rd_q1   <= rd_in_range ? ram[rd_idx] : '0;
            rd_data <= rd_q1;
        end
    end

`ifdef KEY_WEIGHT_SINK_CHECKSUM_EN
    logic [31:0] beat_sum;

    // Zero-extended sum of the elements in the current beat.
    always_comb begin
        beat_sum = '0;
        for (int j = 0; j < PAR; j++) begin
            beat_sum = beat_sum + 32'(data_in[j]);
        end
    end

    // Running checksum; only accepted beats contribute, so it freezes in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (clear) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + beat_sum;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_layer_0_attention_self_key_weight_sink.sv
// Self-checking bench for encoder_layer_0_attention_self_key_weight_sink
// (P=16, DIM_0=8, PARALLELISM=4, MEM_DEPTH=4). A behavioural model of the
// sink is compared against the DUT every cycle, with literal spot checks.
module tb_encoder_layer_0_attention_self_key_weight_sink;

    localparam int P     = 16;
    localparam int DIM   = 8;
    localparam int PAR   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int RW    = P * DIM;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [P-1:0]  data_in [PAR];
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic          clear = 1'b0;
    logic          load_done;
    logic [AW-1:0] row_count;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ce = 1'b0;
    logic [RW-1:0] rd_data;
`ifdef KEY_WEIGHT_SINK_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int checks = 0;
    int errors = 0;
    bit rd_rand = 1'b0;

    encoder_layer_0_attention_self_key_weight_sink #(
        .KEY_WEIGHT_PRECISION_0      (P),
        .KEY_WEIGHT_TENSOR_SIZE_DIM_0(DIM),
        .KEY_WEIGHT_PARALLELISM_DIM_0(PAR),
        .MEM_DEPTH                   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .clear        (clear),
        .load_done    (load_done),
        .row_count    (row_count),
        .rd_addr      (rd_addr),
        .rd_ce        (rd_ce),
        .rd_data      (rd_data)
`ifdef KEY_WEIGHT_SINK_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_rows    = 0;   // committed rows
    int            m_elems   = 0;   // elements held in the partial row
    bit            m_pending = 0;   // a full row waits for its commit cycle
    bit            m_oor     = 0;   // at least one edge seen since reset release
    logic [P-1:0]  m_part [DIM];
    logic [P-1:0]  m_ram [DEPTH][DIM];
    bit            m_written [DEPTH];
    logic [RW-1:0] m_p1 = '0;
    logic [RW-1:0] m_p2 = '0;
    bit            m_v1 = 1'b1;
    bit            m_v2 = 1'b1;
    logic [31:0]   m_sum = '0;
    bit            m_rdy_now;

    function automatic bit m_ready();
        return m_oor && !m_pending && (m_rows < DEPTH) && !clear;
    endfunction

    function automatic logic [RW-1:0] pack_row(input int r);
        logic [RW-1:0] v;
        for (int e = 0; e < DIM; e++) v[P*e +: P] = m_ram[r][e];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rows = 0; m_elems = 0; m_pending = 0; m_oor = 0;
            m_p1 = '0; m_p2 = '0; m_v1 = 1'b1; m_v2 = 1'b1; m_sum = '0;
        end else begin
            m_rdy_now = m_ready();
            if (rd_ce) begin
                m_p2 = m_p1;
                m_v2 = m_v1;
                if (int'(rd_addr) < DEPTH) begin
                    m_p1 = pack_row(int'(rd_addr));
                    m_v1 = m_written[int'(rd_addr)];
                end else begin
                    m_p1 = '0;
                    m_v1 = 1'b1;
                end
            end
            if (clear) begin
                m_rows = 0; m_elems = 0; m_pending = 0; m_sum = '0;
            end else if (m_pending) begin
                m_ram[m_rows] = m_part;
                m_written[m_rows] = 1'b1;
                m_rows++;
                m_pending = 0;
            end else if (data_in_valid && m_rdy_now) begin
                for (int j = 0; j < PAR; j++) begin
                    m_part[m_elems + j] = data_in[j];
                    m_sum = m_sum + 32'(data_in[j]);
                end
                m_elems += PAR;
                if (m_elems == DIM) begin
                    m_elems = 0;
                    m_pending = 1;
                end
            end
            m_oor = 1;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        check("ready", RW'(data_in_ready), RW'(m_ready()));
        check("load_done", RW'(load_done), RW'(m_rows == DEPTH));
        check("row_count", RW'(row_count), RW'(m_rows));
        if (m_v2) check("rd_data", rd_data, m_p2);
`ifdef KEY_WEIGHT_SINK_CHECKSUM_EN
        check("checksum", RW'(checksum), RW'(m_sum));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] beat, input bit gap);
        bit taken;
        taken = 1'b0;
        if (gap) begin
            data_in_valid = 1'b0;
            tick();
        end
        data_in_valid = 1'b1;
        for (int j = 0; j < PAR; j++) data_in[j] = beat[16*j +: 16];
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            if (data_in_ready) taken = 1'b1;
            tick();
        end
        data_in_valid = 1'b0;
        check("beat_accepted", RW'(taken), RW'(1));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (load_done) seen = 1'b1;
        end
        check("load_done_reached", RW'(seen), RW'(1));
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    function automatic logic [63:0] seq_beat(input int b);
        logic [63:0] v;
        for (int j = 0; j < PAR; j++) v[16*j +: 16] = 16'(b * PAR + j);
        return v;
    endfunction

    // Background random readback traffic when enabled.
    initial begin
        forever begin
            tick();
            if (rd_rand) begin
                rd_ce   = 1'($urandom_range(0, 1));
                rd_addr = AW'($urandom_range(0, 7));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [RW-1:0] exp_row2;
        logic [RW-1:0] saved3;
        for (int e = 0; e < DIM; e++) exp_row2[P*e +: P] = 16'(16 + e);
        for (int j = 0; j < PAR; j++) data_in[j] = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("reset_ready", RW'(data_in_ready), RW'(0));
        check("reset_row_count", RW'(row_count), RW'(0));
        check("reset_rd_data", rd_data, RW'(0));
        tick();
        rst = 1'b1;
        tick();

        // Full back-to-back load of elements 0..31
        rd_ce = 1'b1;
        rd_addr = 3'd2;
        for (int b = 0; b < 8; b++) send_beat(seq_beat(b), 1'b0);
        wait_done();
        check("full_row_count", RW'(row_count), RW'(4));
        repeat (3) tick();
        @(negedge clk);
        check("full_row2", rd_data, exp_row2);
        tick();

        // DONE ignores valid
        data_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < PAR; j++) data_in[j] = 16'($urandom);
            tick();
        end
        @(negedge clk);
        check("done_ready", RW'(data_in_ready), RW'(0));
        check("done_row_count", RW'(row_count), RW'(4));
        check("done_row2_kept", rd_data, exp_row2);
        tick();
        data_in_valid = 1'b0;

        // Backpressure: valid every other cycle
        do_clear();
        for (int b = 0; b < 8; b++) send_beat(seq_beat(b), 1'b1);
        wait_done();
        repeat (3) tick();
        @(negedge clk);
        check("bp_row2", rd_data, exp_row2);
        tick();

        // Clear coincident with the 2nd beat of row 1
        do_clear();
        for (int b = 0; b < 3; b++) send_beat({$urandom, $urandom}, 1'b0);
        data_in_valid = 1'b1;
        clear = 1'b1;
        for (int j = 0; j < PAR; j++) data_in[j] = 16'($urandom);
        @(negedge clk);
        check("clear_blocks_ready", RW'(data_in_ready), RW'(0));
        tick();
        clear = 1'b0;
        data_in_valid = 1'b0;
        @(negedge clk);
        check("clear_row_count", RW'(row_count), RW'(0));
        tick();
        for (int b = 0; b < 2; b++) send_beat({$urandom, $urandom}, 1'b0);

        // Randomized traffic with occasional clears
        rd_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            data_in_valid = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < PAR; j++) data_in[j] = 16'($urandom);
            clear = ($urandom_range(0, 39) == 0) || (load_done && $urandom_range(0, 3) == 0);
            tick();
        end
        clear = 1'b0;
        data_in_valid = 1'b0;
        rd_rand = 1'b0;

        // Async reset mid-load after 3 rows
        do_clear();
        for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom}, 1'b0);
        wait_done();
        saved3 = pack_row(3);
        do_clear();
        rd_ce = 1'b1;
        rd_addr = 3'd1;
        for (int b = 0; b < 7; b++) send_beat({$urandom, $urandom}, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_ready", RW'(data_in_ready), RW'(0));
        check("async_row_count", RW'(row_count), RW'(0));
        check("async_load_done", RW'(load_done), RW'(0));
        check("async_rd_data", rd_data, RW'(0));
        tick();
        tick();
        rst = 1'b1;
        rd_addr = 3'd3;
        repeat (4) tick();
        @(negedge clk);
        check("row3_untouched", rd_data, saved3);
        rd_addr = 3'd6;
        repeat (3) tick();
        @(negedge clk);
        check("out_of_range_zero", rd_data, RW'(0));
        tick();

`ifdef KEY_WEIGHT_SINK_CHECKSUM_EN
        // All-ones full load checksum
        do_clear();
        for (int b = 0; b < 8; b++) send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_done();
        @(negedge clk);
        check("checksum_full", RW'(checksum), RW'(32'h001F_FFE0));
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
